// File: rtl/prsg_checker_pkg.sv
// ---------------------------------------------------------------------------
// prsg_pkg
// Shared definitions for the 5-bit PRSG checker and its generator:
// x[n] = x[n-3] ^ x[n-5], period 31.
//   state_e   : checker state (HUNT, VERIFY, LOCKED)
//   LFSR_W    : history length in bits
//   TAP_A/B   : history positions (hist[0] newest) feeding the prediction
//   lfsr_pred : next expected bit given the current history
// ---------------------------------------------------------------------------
package prsg_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_e;

    localparam int LFSR_W = 5;
    localparam int TAP_A  = 2;
    localparam int TAP_B  = 4;

    // hist[TAP_A] is x[n-3] and hist[TAP_B] is x[n-5] when hist[0] holds x[n-1]
    function automatic logic lfsr_pred(input logic [LFSR_W-1:0] hist);
        return hist[TAP_A] ^ hist[TAP_B];
    endfunction

endpackage

// File: rtl/prsg_checker_if.sv
// ---------------------------------------------------------------------------
// prsg_checker_if
// Bundle between a serial PRSG source and the checker.
//   din, din_vld, clr_cnt : source -> checker
//   locked, err, sync_loss, err_cnt : checker -> source/monitor
// Modports: master (drives the stream), slave (the checker).
// ---------------------------------------------------------------------------
interface prsg_checker_if #(
    parameter int ERR_W = 16
);
    logic             din;
    logic             din_vld;
    logic             clr_cnt;
    logic             locked;
    logic             err;
    logic             sync_loss;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output din, din_vld, clr_cnt,
        input  locked, err, sync_loss, err_cnt
    );

    modport slave (
        input  din, din_vld, clr_cnt,
        output locked, err, sync_loss, err_cnt
    );
endinterface

// File: rtl/prsg_checker_sat_cnt.sv
// ---------------------------------------------------------------------------
// sat_cnt
// Width-parameterised saturating up-counter.
//   clk   : clock, posedge
//   rst   : synchronous reset, active-low
//   clr_i : synchronous clear; applied before a same-cycle increment
//   inc_i : increment by one, holds at all-ones
//   cnt_o : registered count
// ---------------------------------------------------------------------------
module sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    // Clear takes priority but a coincident increment still lands, so the
    // cleared count starts at one rather than losing that event.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= inc_i ? W'(1) : '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/prsg_checker.sv
// ---------------------------------------------------------------------------
// prsg_checker
// Receive-side checker for the 5-bit PRSG stream. Synchronises to the
// sequence, flags and counts bit errors, and drops sync when too many errors
// land within one window while locked.
//   clk              : clock, posedge
//   rst              : synchronous reset, active-low
//   bus.din          : received serial bit
//   bus.din_vld      : din qualifier; idle cycles change nothing but err_cnt clear
//   bus.clr_cnt      : synchronous clear of err_cnt
//   bus.locked       : high while in LOCKED
//   bus.err          : one-cycle pulse per mismatching bit while locked
//   bus.sync_loss    : one-cycle pulse on LOCKED -> HUNT
//   bus.err_cnt      : saturating error count, survives sync loss
// Build option PRSG_CHK_SELFSYNC_EN: while locked, shift the received bit
// (instead of the local prediction) into the history, so one line error
// produces three err pulses instead of one.
// ---------------------------------------------------------------------------
module prsg_checker
    import prsg_pkg::*;
#(
    parameter int LOCK_CNT = 8,
    parameter int LOSS_WIN = 31,
    parameter int LOSS_THR = 4,
    parameter int ERR_W    = 16
) (
    input logic         clk,
    input logic         rst,
    prsg_checker_if.slave bus
);

    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W   = $clog2(LOSS_WIN + 1);
    localparam int WERR_W  = $clog2(LOSS_THR + 1);

    state_e              state_q;
    logic [LFSR_W-1:0]   hist_q;
    logic [2:0]          fill_q;
    logic [MATCH_W-1:0]  match_q;
    logic [WIN_W-1:0]    win_q;
    logic [WERR_W-1:0]   winErr_q;
    logic                locked_q;
    logic                err_q;
    logic                syncLoss_q;

    logic                pred;
    logic                bitMiss;
    logic                lockedMiss;
    logic                lossHit;
    logic                lastWinBit;
    logic                histNonZero;
    logic                shiftBit;
    logic [ERR_W-1:0]    errCnt;

    // Prediction and per-bit decisions shared by the FSM and the error counter.
    always_comb begin
        pred        = lfsr_pred(hist_q);
        bitMiss     = bus.din != pred;
        histNonZero = |hist_q;
        lockedMiss  = bus.din_vld && (state_q == LOCKED) && bitMiss;
        lossHit     = lockedMiss && (winErr_q == WERR_W'(LOSS_THR - 1));
        lastWinBit  = win_q == WIN_W'(LOSS_WIN - 1);
`ifdef PRSG_CHK_SELFSYNC_EN
        shiftBit    = bus.din;
`else
        shiftBit    = pred;
`endif
    end

    // Sync FSM. The threshold test uses the error count including the current
    // bit, so an error on the last bit of a window is judged before the
    // window counters clear. An all-zero history never counts as a match,
    // keeping the checker out of the LFSR lockup state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= HUNT;
            hist_q     <= '0;
            fill_q     <= '0;
            match_q    <= '0;
            win_q      <= '0;
            winErr_q   <= '0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            syncLoss_q <= 1'b0;
        end else begin
            err_q      <= lockedMiss;
            syncLoss_q <= lossHit;
            if (bus.din_vld) begin
                unique case (state_q)
                    HUNT: begin
                        hist_q <= {hist_q[LFSR_W-2:0], bus.din};
                        if (fill_q == 3'(LFSR_W - 1)) begin
                            fill_q  <= 3'(LFSR_W);
                            match_q <= '0;
                            state_q <= VERIFY;
                        end else begin
                            fill_q <= fill_q + 3'd1;
                        end
                    end
                    VERIFY: begin
                        hist_q <= {hist_q[LFSR_W-2:0], bus.din};
                        if (!bitMiss && histNonZero) begin
                            if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                                match_q  <= '0;
                                win_q    <= '0;
                                winErr_q <= '0;
                            end else begin
                                match_q <= match_q + MATCH_W'(1);
                            end
                        end else begin
                            match_q <= '0;
                        end
                    end
                    LOCKED: begin
                        if (lossHit) begin
                            state_q  <= HUNT;
                            hist_q   <= '0;
                            fill_q   <= '0;
                            match_q  <= '0;
                            win_q    <= '0;
                            winErr_q <= '0;
                            locked_q <= 1'b0;
                        end else begin
                            hist_q <= {hist_q[LFSR_W-2:0], shiftBit};
                            if (lastWinBit) begin
                                win_q    <= '0;
                                winErr_q <= '0;
                            end else begin
                                win_q <= win_q + WIN_W'(1);
                                if (bitMiss) begin
                                    winErr_q <= winErr_q + WERR_W'(1);
                                end
                            end
                        end
                    end
                    default: begin
                        state_q  <= HUNT;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Error counter; loss of sync deliberately does not clear it.
    sat_cnt #(
        .W(ERR_W)
    ) u_errCnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (bus.clr_cnt),
        .inc_i (lockedMiss),
        .cnt_o (errCnt)
    );

    assign bus.locked    = locked_q;
    assign bus.err       = err_q;
    assign bus.sync_loss = syncLoss_q;
    assign bus.err_cnt   = errCnt;

endmodule
